// File: rtl/dwt_pass_scheduler.sv
// Read/write address sequencer for a multi-level 2-D DWT over ping-pong memories:
// row pass then column pass per level, with the active region shrinking to LL each level.
module dwt_pass_scheduler #(
    parameter int WIDTH   = 256,
    parameter int HEIGHT  = 256,
    parameter int LEVELS  = 1,
    parameter int MAX_OUT = 8,
    localparam int AW     = $clog2(WIDTH * HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [2:0]    level,
    output logic          mode,
    output logic          bank_sel,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [AW-1:0] rd_addr1,
    output logic [AW-1:0] rd_addr2,
    input  logic          i_res_valid,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr_lo,
    output logic [AW-1:0] wr_addr_hi,
    output logic          err
);

    localparam int WL = $clog2(WIDTH);
    localparam int OW = $clog2(MAX_OUT + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ROW       = 3'd1;
    localparam logic [2:0] S_ROW_DRAIN = 3'd2;
    localparam logic [2:0] S_COL       = 3'd3;
    localparam logic [2:0] S_COL_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    localparam logic [AW-1:0] A_ZERO = AW'(0);
    localparam logic [AW-1:0] A_ONE  = AW'(1);
    localparam logic [AW-1:0] A_TWO  = AW'(2);
    localparam logic [OW-1:0] O_ZERO = OW'(0);
    localparam logic [OW-1:0] O_ONE  = OW'(1);
    localparam logic [OW-1:0] O_MAX  = OW'(MAX_OUT);

    logic [2:0]    state_r, state_s;
    logic [AW-1:0] p_r, rc_r, wp_r, wrc_r;
    logic [AW-1:0] p_s, rc_s, wp_s, wrc_s;
    logic [OW-1:0] outstanding_r, outstanding_s;
    logic [2:0]    level_s;
    logic          mode_s, bank_s;
    logic [AW-1:0] wc_s, hc_s, line_len_s, line_cnt_s;
    logic          hs_s, res_ok_s;
    logic          line_end_s, pass_end_s, wline_end_s, wpass_end_s;
    logic [AW-1:0] rd_addr1_s, rd_addr2_s, wlo_s, whi_s;

    // Active-region geometry and the scan boundaries of both the issue and writeback pointers.
    always_comb begin
        wc_s        = AW'(WIDTH >> level);
        hc_s        = AW'(HEIGHT >> level);
        line_len_s  = mode ? hc_s : wc_s;
        line_cnt_s  = mode ? wc_s : hc_s;
        hs_s        = rd_valid & rd_ready;
        res_ok_s    = i_res_valid & busy & (outstanding_r != O_ZERO);
        line_end_s  = (p_r == line_len_s - A_TWO);
        pass_end_s  = line_end_s & (rc_r == line_cnt_s - A_ONE);
        wline_end_s = (wp_r == line_len_s - A_TWO);
        wpass_end_s = wline_end_s & (wrc_r == line_cnt_s - A_ONE);
    end

    // Pass sequencing: level, mode and bank only change once the datapath has fully drained.
    always_comb begin
        state_s = state_r;
        level_s = level;
        mode_s  = mode;
        bank_s  = bank_sel;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_ROW;
                    level_s = 3'd0;
                    mode_s  = 1'b0;
                    bank_s  = 1'b0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ROW: begin
                if (hs_s && pass_end_s) state_s = S_ROW_DRAIN;
                else                    state_s = S_ROW;
            end
            S_ROW_DRAIN: begin
                if (outstanding_r == O_ZERO) begin
                    state_s = S_COL;
                    mode_s  = 1'b1;
                    bank_s  = ~bank_sel;
                end else begin
                    state_s = S_ROW_DRAIN;
                end
            end
            S_COL: begin
                if (hs_s && pass_end_s) state_s = S_COL_DRAIN;
                else                    state_s = S_COL;
            end
            S_COL_DRAIN: begin
                if (outstanding_r == O_ZERO) begin
                    bank_s  = ~bank_sel;
                    level_s = level + 3'd1;
                    if (32'(level) + 32'd1 == LEVELS) begin
                        state_s = S_DONE;
                    end else begin
                        state_s = S_ROW;
                        mode_s  = 1'b0;
                    end
                end else begin
                    state_s = S_COL_DRAIN;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Issue and writeback pointers walk the same scan; both wrap to zero at pass end.
    always_comb begin
        p_s   = p_r;
        rc_s  = rc_r;
        wp_s  = wp_r;
        wrc_s = wrc_r;
        if (state_r == S_IDLE) begin
            p_s   = A_ZERO;
            rc_s  = A_ZERO;
            wp_s  = A_ZERO;
            wrc_s = A_ZERO;
        end else begin
            if (hs_s) begin
                if (line_end_s) begin
                    p_s  = A_ZERO;
                    rc_s = pass_end_s ? A_ZERO : rc_r + A_ONE;
                end else begin
                    p_s  = p_r + A_TWO;
                end
            end else begin
                p_s = p_r;
            end
            if (res_ok_s) begin
                if (wline_end_s) begin
                    wp_s  = A_ZERO;
                    wrc_s = wpass_end_s ? A_ZERO : wrc_r + A_ONE;
                end else begin
                    wp_s  = wp_r + A_TWO;
                end
            end else begin
                wp_s = wp_r;
            end
        end
    end

    // Outstanding pairs and the registered read request for the next cycle.
    always_comb begin
        case ({hs_s, res_ok_s})
            2'b10:   outstanding_s = outstanding_r + O_ONE;
            2'b01:   outstanding_s = outstanding_r - O_ONE;
            default: outstanding_s = outstanding_r;
        endcase
        if (mode_s) begin
            rd_addr1_s = (p_s << WL) + rc_s;
            rd_addr2_s = rd_addr1_s + AW'(WIDTH);
        end else begin
            rd_addr1_s = (rc_s << WL) + p_s;
            rd_addr2_s = rd_addr1_s + A_ONE;
        end
    end

    // Low/high band destinations for the result currently presented by the datapath.
    always_comb begin
        if (mode) begin
            wlo_s = ((wp_r >> 1) << WL) + wrc_r;
            whi_s = wlo_s + ((hc_s >> 1) << WL);
        end else begin
            wlo_s = (wrc_r << WL) + (wp_r >> 1);
            whi_s = wlo_s + (wc_s >> 1);
        end
    end

    assign wr_en      = res_ok_s;
    assign wr_addr_lo = busy ? wlo_s : A_ZERO;
    assign wr_addr_hi = busy ? whi_s : A_ZERO;

    // State, pointers and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= S_IDLE;
            p_r           <= A_ZERO;
            rc_r          <= A_ZERO;
            wp_r          <= A_ZERO;
            wrc_r         <= A_ZERO;
            outstanding_r <= O_ZERO;
            level         <= 3'd0;
            mode          <= 1'b0;
            bank_sel      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            rd_valid      <= 1'b0;
            rd_addr1      <= A_ZERO;
            rd_addr2      <= A_ZERO;
            err           <= 1'b0;
        end else begin
            state_r       <= state_s;
            p_r           <= p_s;
            rc_r          <= rc_s;
            wp_r          <= wp_s;
            wrc_r         <= wrc_s;
            outstanding_r <= outstanding_s;
            level         <= level_s;
            mode          <= mode_s;
            bank_sel      <= bank_s;
            busy          <= (state_s != S_IDLE) && (state_s != S_DONE);
            done          <= (state_s == S_DONE);
            rd_valid      <= ((state_s == S_ROW) || (state_s == S_COL)) && (outstanding_s < O_MAX);
            rd_addr1      <= rd_addr1_s;
            rd_addr2      <= rd_addr2_s;
            err           <= err | (i_res_valid & (outstanding_r == O_ZERO));
        end
    end

endmodule

// File: tb/tb_dwt_pass_scheduler.sv
// Directed bench for dwt_pass_scheduler at 8x8, two levels; a second instance with MAX_OUT=2
// exercises the outstanding limit.
module tb_dwt_pass_scheduler;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, rd_ready, man_res, auto_ret;
    logic          busy, done, mode, bank_sel, rd_valid, i_res_valid, wr_en, err;
    logic [2:0]    level;
    logic [AW-1:0] rd_addr1, rd_addr2, wr_addr_lo, wr_addr_hi;

    logic          start2, rd_ready2, i_res_valid2;
    logic          busy2, done2, mode2, bank_sel2, rd_valid2, wr_en2, err2;
    logic [2:0]    level2;
    logic [AW-1:0] rd_addr1_2, rd_addr2_2, wr_addr_lo2, wr_addr_hi2;

    logic [2:0]    pipe;
    int            checks = 0;
    int            errors = 0;
    int            done_cnt = 0;
    int            hs2_cnt = 0;
    logic [AW-1:0] iss1[$], iss2[$], wlo[$], whi[$];
    logic          imode[$], ibank[$];
    logic [2:0]    ilvl[$];

    always #5 clk = ~clk;

    dwt_pass_scheduler #(.WIDTH(8), .HEIGHT(8), .LEVELS(2), .MAX_OUT(8)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .level(level),
        .mode(mode), .bank_sel(bank_sel), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .i_res_valid(i_res_valid), .wr_en(wr_en),
        .wr_addr_lo(wr_addr_lo), .wr_addr_hi(wr_addr_hi), .err(err));

    dwt_pass_scheduler #(.WIDTH(8), .HEIGHT(8), .LEVELS(2), .MAX_OUT(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .level(level2),
        .mode(mode2), .bank_sel(bank_sel2), .rd_valid(rd_valid2), .rd_ready(rd_ready2),
        .rd_addr1(rd_addr1_2), .rd_addr2(rd_addr2_2), .i_res_valid(i_res_valid2), .wr_en(wr_en2),
        .wr_addr_lo(wr_addr_lo2), .wr_addr_hi(wr_addr_hi2), .err(err2));

    // Datapath model: each accepted pair returns its result three cycles later.
    always @(posedge clk or posedge rst) begin
        if (rst) pipe <= 3'b000;
        else     pipe <= {pipe[1:0], rd_valid & rd_ready};
    end
    assign i_res_valid = (auto_ret & pipe[2]) | man_res;

    // Monitor: record every handshake, write and done pulse.
    always @(posedge clk) begin
        if (rd_valid && rd_ready) begin
            iss1.push_back(rd_addr1); iss2.push_back(rd_addr2);
            imode.push_back(mode); ibank.push_back(bank_sel); ilvl.push_back(level);
        end
        if (wr_en) begin
            wlo.push_back(wr_addr_lo); whi.push_back(wr_addr_hi);
        end
        if (done) done_cnt++;
        if (rd_valid2 && rd_ready2) hs2_cnt++;
    end

    task automatic test_reset;
        #2;
        checks++;
        if ({busy, done, level, mode, bank_sel, rd_valid, rd_addr1, rd_addr2, wr_en, wr_addr_lo, wr_addr_hi, err} !== 33'd0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", {busy, done, level, mode, bank_sel, rd_valid, rd_addr1, rd_addr2, wr_en, wr_addr_lo, wr_addr_hi, err});
        end
        checks++;
        if ({busy2, rd_valid2, rd_addr1_2, err2} !== 15'd0) begin
            errors++; $display("FAIL reset_outputs2: got %h expected 0", {busy2, rd_valid2, rd_addr1_2, err2});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_full_transform;
        int b = iss1.size();
        int bw = wlo.size();
        int bd = done_cnt;
        rd_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++;
        if ({busy, rd_valid, rd_addr1, rd_addr2} !== {1'b1, 1'b1, 6'd0, 6'd1}) begin
            errors++; $display("FAIL issue_latency: got busy=%b valid=%b (%0d,%0d) expected 1 1 (0,1)", busy, rd_valid, rd_addr1, rd_addr2);
        end
        for (int i = 0; i < 2000 && done_cnt == bd; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt != bd + 1) begin
            errors++; $display("FAIL done_pulse: got %0d pulse cycles expected 1", done_cnt - bd);
        end
        checks++;
        if (iss1.size() - b != 80 || wlo.size() - bw != 80) begin
            errors++; $display("FAIL pair_count: got %0d issues %0d writes expected 80 80", iss1.size() - b, wlo.size() - bw);
        end else begin
            checks++;
            if ({iss1[b], iss2[b], iss1[b+31], iss2[b+31]} !== {6'd0, 6'd1, 6'd62, 6'd63}) begin
                errors++; $display("FAIL row0_addrs: got (%0d,%0d) (%0d,%0d) expected (0,1) (62,63)", iss1[b], iss2[b], iss1[b+31], iss2[b+31]);
            end
            checks++;
            if ({imode[b+31], ibank[b+31], imode[b+32], ibank[b+32]} !== 4'b0011) begin
                errors++; $display("FAIL row_col_switch: got mode/bank %b%b -> %b%b expected 00 -> 11", imode[b+31], ibank[b+31], imode[b+32], ibank[b+32]);
            end
            checks++;
            if ({iss1[b+32], iss2[b+32], iss1[b+33], iss2[b+33]} !== {6'd0, 6'd8, 6'd16, 6'd24}) begin
                errors++; $display("FAIL col0_addrs: got (%0d,%0d) (%0d,%0d) expected (0,8) (16,24)", iss1[b+32], iss2[b+32], iss1[b+33], iss2[b+33]);
            end
            checks++;
            if ({wlo[bw], whi[bw], wlo[bw+31], whi[bw+31]} !== {6'd0, 6'd4, 6'd59, 6'd63}) begin
                errors++; $display("FAIL row0_writes: got (%0d,%0d) (%0d,%0d) expected (0,4) (59,63)", wlo[bw], whi[bw], wlo[bw+31], whi[bw+31]);
            end
            checks++;
            if ({wlo[bw+32], whi[bw+32], wlo[bw+33], whi[bw+33]} !== {6'd0, 6'd32, 6'd8, 6'd40}) begin
                errors++; $display("FAIL col0_writes: got (%0d,%0d) (%0d,%0d) expected (0,32) (8,40)", wlo[bw+32], whi[bw+32], wlo[bw+33], whi[bw+33]);
            end
            checks++;
            if ({ilvl[b+64], imode[b+64], ibank[b+64], iss1[b+71], iss2[b+71]} !== {3'd1, 1'b0, 1'b0, 6'd26, 6'd27}) begin
                errors++; $display("FAIL row1: got lvl=%0d mode=%b bank=%b last=(%0d,%0d) expected 1 0 0 (26,27)", ilvl[b+64], imode[b+64], ibank[b+64], iss1[b+71], iss2[b+71]);
            end
            checks++;
            if ({wlo[bw+64], whi[bw+64], wlo[bw+71], whi[bw+71]} !== {6'd0, 6'd2, 6'd25, 6'd27}) begin
                errors++; $display("FAIL row1_writes: got (%0d,%0d) (%0d,%0d) expected (0,2) (25,27)", wlo[bw+64], whi[bw+64], wlo[bw+71], whi[bw+71]);
            end
            checks++;
            if ({imode[b+72], ibank[b+72], iss1[b+79], iss2[b+79], wlo[bw+72], whi[bw+72], wlo[bw+79], whi[bw+79]} !== {1'b1, 1'b1, 6'd19, 6'd27, 6'd0, 6'd16, 6'd11, 6'd27}) begin
                errors++; $display("FAIL col1: got mode=%b bank=%b last=(%0d,%0d) w0=(%0d,%0d) wl=(%0d,%0d) expected 1 1 (19,27) (0,16) (11,27)",
                                   imode[b+72], ibank[b+72], iss1[b+79], iss2[b+79], wlo[bw+72], whi[bw+72], wlo[bw+79], whi[bw+79]);
            end
        end
        checks++;
        if ({busy, bank_sel, err} !== 3'b000) begin
            errors++; $display("FAIL end_state: got busy=%b bank=%b err=%b expected 0 0 0", busy, bank_sel, err);
        end
    endtask

    task automatic test_stall;
        int b = iss1.size();
        int bd = done_cnt;
        rd_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            @(negedge clk);
            checks++;
            if ({rd_valid, rd_addr1, rd_addr2} !== {1'b1, 6'd6, 6'd7}) begin
                errors++; $display("FAIL stall_hold: cycle %0d got valid=%b (%0d,%0d) expected 1 (6,7)", i, rd_valid, rd_addr1, rd_addr2);
            end
        end
        start = 1'b0;
        rd_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({rd_addr1, rd_addr2} !== {6'd8, 6'd9}) begin
            errors++; $display("FAIL stall_resume: got (%0d,%0d) expected (8,9)", rd_addr1, rd_addr2);
        end
        for (int i = 0; i < 2000 && done_cnt == bd; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (done_cnt != bd + 1 || iss1.size() - b != 80) begin
            errors++; $display("FAIL stall_run: got %0d done %0d issues expected 1 80", done_cnt - bd, iss1.size() - b);
        end else begin
            checks++;
            if ({iss1[b+3], iss1[b+4]} !== {6'd6, 6'd8}) begin
                errors++; $display("FAIL stall_no_skip: got %0d %0d expected 6 8", iss1[b+3], iss1[b+4]);
            end
        end
    endtask

    task automatic test_max_out;
        rd_ready2 = 1'b1;
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({hs2_cnt[7:0], rd_valid2, rd_addr1_2} !== {8'd2, 1'b0, 6'd4}) begin
            errors++; $display("FAIL max_out_limit: got %0d issues valid=%b addr=%0d expected 2 0 4", hs2_cnt, rd_valid2, rd_addr1_2);
        end
        i_res_valid2 = 1'b1;
        #1;
        checks++;
        if ({wr_en2, wr_addr_lo2, wr_addr_hi2} !== {1'b1, 6'd0, 6'd4}) begin
            errors++; $display("FAIL max_out_wr0: got en=%b (%0d,%0d) expected 1 (0,4)", wr_en2, wr_addr_lo2, wr_addr_hi2);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({rd_valid2, rd_addr1_2, wr_en2, wr_addr_lo2, wr_addr_hi2} !== {1'b1, 6'd4, 1'b1, 6'd1, 6'd5}) begin
            errors++; $display("FAIL max_out_resume: got valid=%b addr=%0d en=%b (%0d,%0d) expected 1 4 1 (1,5)", rd_valid2, rd_addr1_2, wr_en2, wr_addr_lo2, wr_addr_hi2);
        end
        @(negedge clk);
        i_res_valid2 = 1'b0;
        checks++;
        if ({rd_valid2, rd_addr1_2, rd_addr2_2} !== {1'b1, 6'd6, 6'd7}) begin
            errors++; $display("FAIL simul_issue_return: got valid=%b (%0d,%0d) expected 1 (6,7)", rd_valid2, rd_addr1_2, rd_addr2_2);
        end
        @(negedge clk);
        checks++;
        if ({rd_valid2, err2} !== 2'b00) begin
            errors++; $display("FAIL max_out_refill: got valid=%b err=%b expected 0 0", rd_valid2, err2);
        end
        rd_ready2 = 1'b0;
    endtask

    task automatic test_err;
        rd_ready = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        man_res = 1'b1;
        #1;
        checks++;
        if ({busy, wr_en} !== 2'b10) begin
            errors++; $display("FAIL err_no_wr: got busy=%b wr_en=%b expected 1 0", busy, wr_en);
        end
        @(negedge clk);
        man_res = 1'b0;
        checks++;
        if ({err, rd_addr1} !== {1'b1, 6'd0}) begin
            errors++; $display("FAIL err_sticky: got err=%b addr=%0d expected 1 0", err, rd_addr1);
        end
    endtask

    task automatic test_abort;
        int bd;
        rd_ready = 1'b1;
        for (int i = 0; i < 500 && mode !== 1'b1; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        checks++;
        if ({mode, busy, level} !== {1'b1, 1'b1, 3'd0}) begin
            errors++; $display("FAIL abort_setup: got mode=%b busy=%b level=%0d expected 1 1 0", mode, busy, level);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, level, mode, bank_sel, rd_valid, rd_addr1, rd_addr2, wr_en, wr_addr_lo, wr_addr_hi, err} !== 33'd0) begin
            errors++; $display("FAIL abort_outputs: got %h expected 0", {busy, done, level, mode, bank_sel, rd_valid, rd_addr1, rd_addr2, wr_en, wr_addr_lo, wr_addr_hi, err});
        end
        @(negedge clk);
        rst = 1'b0;
        bd = done_cnt;
        repeat (20) @(negedge clk);
        checks++;
        if (done_cnt != bd || busy !== 1'b0) begin
            errors++; $display("FAIL abort_no_done: got %0d pulses busy=%b expected 0 0", done_cnt - bd, busy);
        end
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++;
        if ({busy, rd_valid, level, mode, rd_addr1, rd_addr2} !== {1'b1, 1'b1, 3'd0, 1'b0, 6'd0, 6'd1}) begin
            errors++; $display("FAIL abort_restart: got busy=%b valid=%b lvl=%0d mode=%b (%0d,%0d) expected 1 1 0 0 (0,1)", busy, rd_valid, level, mode, rd_addr1, rd_addr2);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rd_ready = 1'b0; man_res = 1'b0; auto_ret = 1'b1;
        start2 = 1'b0; rd_ready2 = 1'b0; i_res_valid2 = 1'b0;
        test_reset;
        test_full_transform;
        test_stall;
        test_max_out;
        test_err;
        test_abort;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
